dffmem_arbiter: RTL

Round-robin access controller that shares the single-port 8x16 DFF memory between NREQ independent requesters. After every reset it runs a clear sweep that writes zero to every word. It then accepts one read or write command per cycle, with a valid/ready handshake per requester. It sits between the requester logic and the memory macro's addr/we/wdata/rdata pins inside tt_um_mem.

---
 rtl/dffmem_pkg.sv | 14 +
 rtl/dffmem_arbiter_rr.sv | 35 +++
 rtl/dffmem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/dffmem_pkg.sv
// dffmem_pkg: shared defaults and types for the DFF memory arbiter.
// Word width, address width, depth and the controller state encoding.
package dffmem_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;
  localparam int DEPTH  = 2 ** AW_DEF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dffmem_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant starting at rr, plus next rr.
// Ports: en, req, rr in; gnt (one-hot), win (index), rr_nx out.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win,
  output logic [IW-1:0]   rr_nx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(rr) + k) % NREQ);
      if (en && !found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) gnt[win] = 1'b1;
    if (int'(win) == NREQ - 1) rr_nx = '0;
    else rr_nx = win + 1'b1;
  end

endmodule

// File: rtl/dffmem_arbiter.sv
// dffmem_arbiter: round-robin shared access to a single-port DFF memory.
// Ports: req/req_we/req_addr/req_wdata -> gnt; rvalid/rdata; mem_* pins.
module dffmem_arbiter
  import dffmem_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NREQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             init_done,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic [IW-1:0] rr, rr_nx, win;
  logic [NREQ-1:0] gnt_w;
  logic          acc;
  logic          v1, v2;
  logic [IW-1:0] own1, own2;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .en    (state == RUN),
    .req   (req),
    .rr    (rr),
    .gnt   (gnt_w),
    .win   (win),
    .rr_nx (rr_nx)
  );

  assign gnt   = gnt_w;
  assign acc   = |(req & gnt_w);
  assign rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (&cnt) state_nx = RUN;
      RUN:   state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    init_done = (state == RUN);
  end

  // Sweep counter, memory pin registers, rr pointer and read-owner pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rr        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      own1      <= '0;
      own2      <= '0;
    end else begin
      if (state == CLEAR) begin
        mem_we    <= 1'b1;
        mem_addr  <= cnt;
        mem_wdata <= '0;
        cnt       <= cnt + 1'b1;
      end else if (acc) begin
        mem_we    <= req_we[win];
        mem_addr  <= req_addr[int'(win)*AW +: AW];
        mem_wdata <= req_wdata[int'(win)*DW +: DW];
        rr        <= rr_nx;
      end else begin
        mem_we <= 1'b0;
      end
      v1   <= acc & ~req_we[win];
      own1 <= win;
      v2   <= v1;
      own2 <= own1;
    end
  end

  always_comb begin
    rvalid = '0;
    if (v2) rvalid[own2] = 1'b1;
  end

endmodule
